// File: rtl/comp_n_seq_if.sv
// Request/response bundle for the sequential magnitude comparator.
// The master drives the operands and start; the slave returns status and result flags.
interface comp_n_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_gt_B;
    logic             A_lt_B;
    logic             A_eq_B;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, A_gt_B, A_lt_B, A_eq_B
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, A_gt_B, A_lt_B, A_eq_B
    );
endinterface

// File: rtl/comp_n_seq.sv
// Sequential MSB-first magnitude comparator: DIGIT bits per clock, early exit on
// the first differing digit, unsigned or two's-complement operands.

// One digit slice; flip inverts the top bit so two's-complement order maps to unsigned order.
module comp_n_seq_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             flip,
    output logic             gt,
    output logic             lt
);
    logic [DIGIT-1:0] msk;
    logic [DIGIT-1:0] fa;
    logic [DIGIT-1:0] fb;

    always_comb begin
        msk            = '0;
        msk[DIGIT-1]   = flip;
        fa             = a ^ msk;
        fb             = b ^ msk;
        gt             = (fa > fb);
        lt             = (fa < fb);
    end
endmodule

module comp_n_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    comp_n_seq_if.slave   bus
);
    localparam int NUM_DIG = WIDTH / DIGIT;
    localparam int KW      = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic                              smode;
        logic [NUM_DIG-1:0][DIGIT-1:0]     a;
        logic [NUM_DIG-1:0][DIGIT-1:0]     b;
    } req_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } rsp_t;

    state_t          state_q;
    req_t            req_q;
    rsp_t            res_q;
    rsp_t            flags_q;
    logic [KW-1:0]   k_q;
    logic            busy_q;
    logic            done_q;

    logic [NUM_DIG-1:0] dig_gt;
    logic [NUM_DIG-1:0] dig_lt;
    logic               cur_gt;
    logic               cur_lt;

    // Every digit is compared in parallel; the scan index picks which one decides this cycle.
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        comp_n_seq_digit #(.DIGIT(DIGIT)) u_dig (
            .a    (req_q.a[i]),
            .b    (req_q.b[i]),
            .flip (req_q.smode && (i == NUM_DIG - 1)),
            .gt   (dig_gt[i]),
            .lt   (dig_lt[i])
        );
    end

    assign cur_gt = dig_gt[k_q];
    assign cur_lt = dig_lt[k_q];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            req_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        req_q.smode <= bus.signed_mode;
                        req_q.a     <= bus.A;
                        req_q.b     <= bus.B;
                        k_q         <= KW'(NUM_DIG - 1);
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_gt || cur_lt) begin
                        res_q   <= '{gt: cur_gt, lt: cur_lt, eq: 1'b0};
                        state_q <= FINISH;
                    end else if (k_q == '0) begin
                        res_q   <= '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
                        state_q <= FINISH;
                    end else begin
                        k_q <= k_q - KW'(1);
                    end
                end
                FINISH: begin
                    // Flags are published only here so they hold steady between results.
                    flags_q <= res_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.A_gt_B = flags_q.gt;
    assign bus.A_lt_B = flags_q.lt;
    assign bus.A_eq_B = flags_q.eq;
endmodule

// File: tb/tb_comp_n_seq.sv
// Bench for comp_n_seq: DIGIT=2, 1 and 16 builds driven in lockstep and checked every
// cycle against a latency/result model, plus directed literal cases.
module tb_comp_n_seq;
    logic        clk   = 1'b0;
    logic        rst_b = 1'b1;
    logic        start = 1'b0;
    logic        smode = 1'b0;
    logic [15:0] a_in  = '0;
    logic [15:0] b_in  = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    comp_n_seq_if #(.WIDTH(16)) if_d2 ();
    comp_n_seq_if #(.WIDTH(16)) if_d1 ();
    comp_n_seq_if #(.WIDTH(16)) if_d16 ();

    assign if_d2.start  = start;  assign if_d2.signed_mode  = smode;
    assign if_d2.A      = a_in;   assign if_d2.B            = b_in;
    assign if_d1.start  = start;  assign if_d1.signed_mode  = smode;
    assign if_d1.A      = a_in;   assign if_d1.B            = b_in;
    assign if_d16.start = start;  assign if_d16.signed_mode = smode;
    assign if_d16.A     = a_in;   assign if_d16.B           = b_in;

    comp_n_seq #(.WIDTH(16), .DIGIT(2))  u_d2  (.clk(clk), .rst_b(rst_b), .bus(if_d2.slave));
    comp_n_seq #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst_b(rst_b), .bus(if_d1.slave));
    comp_n_seq #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst_b(rst_b), .bus(if_d16.slave));

    // {busy, done, gt, lt, eq} per build
    logic [4:0] dut_o [3];
    assign dut_o[0] = {if_d2.busy,  if_d2.done,  if_d2.A_gt_B,  if_d2.A_lt_B,  if_d2.A_eq_B};
    assign dut_o[1] = {if_d1.busy,  if_d1.done,  if_d1.A_gt_B,  if_d1.A_lt_B,  if_d1.A_eq_B};
    assign dut_o[2] = {if_d16.busy, if_d16.done, if_d16.A_gt_B, if_d16.A_lt_B, if_d16.A_eq_B};

    string nm [3] = '{"d2", "d1", "d16"};

    function automatic int dg_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 16;
    endfunction

    // SCAN cycles = digits examined up to and including the one holding the top differing bit.
    function automatic int lat_of(input logic [15:0] a, input logic [15:0] b, input int dg);
        logic [15:0] x;
        int h;
        x = a ^ b;
        h = -1;
        for (int i = 0; i < 16; i++) if (x[i]) h = i;
        if (h < 0) return 16 / dg;
        return 16 / dg - h / dg;
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b, input logic m);
        if (m) return {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b};
        return {a > b, a < b, a == b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining busy cycles, pending result and published flags per build.
    int         m_cnt   [3];
    logic [2:0] m_pend  [3];
    logic [2:0] m_flags [3];
    logic       m_done  [3];

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int d = 0; d < 3; d++) begin
                m_cnt[d] = 0; m_pend[d] = '0; m_flags[d] = '0; m_done[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_done[d] = 1'b0;
                if (m_cnt[d] > 0) begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        m_done[d]  = 1'b1;
                        m_flags[d] = m_pend[d];
                    end
                end else if (start) begin
                    m_cnt[d]  = lat_of(a_in, b_in, dg_of(d)) + 1;
                    m_pend[d] = ref_cmp(a_in, b_in, smode);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++)
            chk({"cyc_", nm[d]}, 32'(dut_o[d]), 32'({m_cnt[d] > 0, m_done[d], m_flags[d]}));
    end

    task automatic run_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input bit inject, input logic [2:0] exp,
                           input int l2, input int l1, input int l16);
        int         seen [3];
        int         exp_l [3];
        logic [2:0] fl [3];
        exp_l = '{l2, l1, l16};
        for (int d = 0; d < 3; d++) begin seen[d] = 0; fl[d] = '0; end
        @(posedge clk); #1;
        start = 1'b1; a_in = a; b_in = b; smode = m;
        @(posedge clk); #1;
        if (inject) begin
            start = 1'b1; a_in = 16'd1; b_in = 16'd9; smode = 1'b0;
        end else begin
            start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); smode = 1'($urandom);
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); smode = 1'($urandom);
            for (int d = 0; d < 3; d++)
                if (dut_o[d][3] && seen[d] == 0) begin
                    seen[d] = n;
                    fl[d]   = dut_o[d][2:0];
                end
            if (seen[0] != 0 && seen[1] != 0 && seen[2] != 0) break;
        end
        for (int d = 0; d < 3; d++) begin
            chk({name, "_lat_", nm[d]}, 32'(seen[d]), 32'(exp_l[d]));
            chk({name, "_flags_", nm[d]}, 32'(fl[d]), 32'(exp));
        end
    endtask

    initial begin
        int nd;
        #1 rst_b = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) chk({"reset_", nm[d]}, 32'(dut_o[d]), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_b = 1'b1;

        // flags {gt, lt, eq}
        run_lit("u_early",  16'h8000, 16'h7FFF, 1'b0, 1'b0, 3'b100, 2, 2, 2);
        run_lit("s_early",  16'h8000, 16'h7FFF, 1'b1, 1'b0, 3'b010, 2, 2, 2);
        run_lit("eq_worst", 16'h1234, 16'h1234, 1'b0, 1'b0, 3'b001, 9, 17, 2);
        run_lit("lsb_lt",   16'h0001, 16'h0002, 1'b0, 1'b0, 3'b010, 9, 16, 2);
        run_lit("s_negneg", 16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 3'b010, 9, 17, 2);
        run_lit("busy_ign", 16'd5,    16'd3,    1'b0, 1'b1, 3'b100, 8, 15, 2);
        run_lit("restart",  16'd1,    16'd9,    1'b0, 1'b0, 3'b010, 8, 14, 2);

        // Abort a long scan with reset: outputs clear at once, no done afterwards.
        @(posedge clk); #1;
        start = 1'b1; a_in = 16'h0001; b_in = 16'h0002; smode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk({"rst_mid_", nm[d]}, 32'(dut_o[d]), 32'd0);
        @(posedge clk); #1 rst_b = 1'b1;
        nd = 0;
        repeat (20) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (dut_o[d][3]) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);

        // Random traffic: starts at any time, operands biased toward near-equal values.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_b = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            start = ($urandom_range(0, 2) == 0);
            a_in  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b_in = a_in;
                1:       b_in = a_in ^ (16'd1 << $urandom_range(0, 15));
                default: b_in = 16'($urandom);
            endcase
            smode = 1'($urandom);
        end
        @(posedge clk); #1;
        rst_b = 1'b1; start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
